instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: DEPTH, 4, prefetch FIFO entries; legal values 2, 4 or 8.
REQ-002 Parameter: RESET_PC, 16'h0000, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: mem_req  output  1  fetch request to instruction memory.
REQ-006 Port: mem_addr  output  16  word address of the current request.
REQ-007 Port: mem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-008 Port: mem_rdata  input  16  instruction word; valid only when mem_ack=1.
REQ-009 Port: instr_valid  output  1  FIFO head holds a valid instruction.
REQ-010 Port: instr  output  16  FIFO head instruction, consumed by the datapath.
REQ-011 Port: instr_pc  output  16  address of instr.
REQ-012 Port: instr_ready  input  1  datapath consumes the head this cycle.
REQ-013 Port: redirect  input  1  jump or taken branch; discard all prefetched work.
REQ-014 Port: redirect_pc  input  16  new fetch address, sampled when redirect=1.

Function
REQ-015 The block SHALL hold fetch_pc, a DEPTH-entry FIFO of {pc, instr} pairs, an occupancy count (0..DEPTH) and a 3-state FSM: IDLE, REQ, DROP.
REQ-016 instr_valid SHALL equal (count!=0); instr and instr_pc SHALL present the FIFO head combinationally from registers.
REQ-017 Dequeue SHALL occur on a clock edge where instr_valid=1, instr_ready=1 and redirect=0; instr_ready with instr_valid=0 SHALL be ignored.
REQ-018 In IDLE, the FSM SHALL move to REQ, asserting mem_req=1 and mem_addr=fetch_pc, whenever count after this cycle's dequeue is < DEPTH; otherwise it SHALL stay in IDLE with mem_req=0.
REQ-019 While in REQ or DROP, mem_req SHALL remain 1 and mem_addr SHALL remain stable until mem_ack=1.
REQ-020 Requests SHALL be single-outstanding.
REQ-021 In REQ, mem_ack=1 with redirect=0 SHALL enqueue {fetch_pc, mem_rdata} and increment fetch_pc modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-022 On the REQ ack edge, the FSM SHALL go to REQ again with the new address if there is space, else to IDLE; back-to-back requests with one fetch per cycle SHALL be possible.
REQ-023 A simultaneous enqueue and dequeue SHALL leave count unchanged; the issue rule SHALL guarantee count never exceeds DEPTH.
REQ-024 On redirect=1, the block SHALL set count to 0, set fetch_pc to redirect_pc and drop any same-cycle mem_ack data; instr_valid SHALL be 0 in the next cycle.
REQ-025 If redirect=1 in REQ with mem_ack=0, the FSM SHALL enter DROP and keep the old address.
REQ-026 In DROP, the ack SHALL be discarded and the FSM SHALL then move to REQ at fetch_pc.
REQ-027 If redirect=1 in REQ with mem_ack=1, or in IDLE, the FSM SHALL go directly to REQ at redirect_pc.
REQ-028 If redirect=1 in DROP, fetch_pc SHALL be updated and the FSM SHALL remain in DROP.
REQ-029 Redirect SHALL take priority over dequeue and enqueue.

Reset
REQ-030 When rst_n=0 (asynchronously, including mid-request), the block SHALL set the FSM to IDLE, count=0, fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=16'h0000 and instr_pc=16'h0000.
REQ-031 The first request SHALL issue in the first cycle after rst_n deasserts.

Verification
REQ-032 Reset release, mem_ack tied 1, instr_ready=0, DEPTH=4 -> addresses 0,1,2,3 fetched on consecutive cycles; count=4; mem_req=0 thereafter.
REQ-033 FIFO full, instr_ready pulsed 1 cycle -> exactly one new request issues (address 4); instr_pc sequence is 0,1,2,... with no gaps.
REQ-034 mem_ack delayed 3 cycles -> mem_req and mem_addr stay stable for all 4 cycles; the entry is enqueued only on the ack edge.
REQ-035 Request to 5 outstanding, redirect to 16'h0040 with mem_ack=0 -> FSM enters DROP; data from 5 is discarded; the next request is 16'h0040; instr_valid=0 until 16'h0040 is enqueued.
REQ-036 redirect_pc=16'hFFFF, ready=1 -> instr_pc sequence is FFFF, 0000, 0001.
REQ-037 rst_n pulsed low during REQ with count=3 -> mem_req=0 and instr_valid=0 immediately, without waiting for a clock; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack channel, the
// instruction delivery channel towards the datapath, and the redirect input.
//   master : the fetch unit (drives mem_req/mem_addr and the instr_* outputs)
//   slave  : the environment (memory, datapath and branch unit)
interface instr_fetch_unit_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_pc;

   modport master (
      output mem_req, mem_addr, instr_valid, instr, instr_pc,
      input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr, instr_pc,
      output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single-outstanding word fetches to
// instruction memory, buffers {pc, instr} pairs in a DEPTH-entry prefetch FIFO
// and hands the FIFO head to the datapath. A redirect flushes the FIFO and
// restarts fetching at redirect_pc; a request already in flight when the
// redirect arrives is waited out and its data dropped.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus.mem_req/addr    : fetch request and word address (registered)
//   bus.mem_ack/rdata   : memory accept with same-cycle data
//   bus.instr_valid/instr/instr_pc : FIFO head towards the datapath
//   bus.instr_ready     : datapath consumes the head
//   bus.redirect/redirect_pc : flush and new fetch address
// DEPTH must be 2, 4 or 8.
module instr_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic              clk,
   input logic              rst_n,
   instr_fetch_unit_if.master bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

   state_t             state, state_nxt;
   logic [15:0]        fetch_pc, fetch_pc_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
   logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
   logic               mem_req, mem_req_nxt;
   logic [15:0]        mem_addr, mem_addr_nxt;
   logic [15:0]        pc_mem   [DEPTH];
   logic [15:0]        data_mem [DEPTH];
   logic               deq, enq, space;

   // FIFO head presented straight from the storage registers
   assign bus.instr_valid = (count != '0);
   assign bus.instr       = data_mem[rd_ptr];
   assign bus.instr_pc    = pc_mem[rd_ptr];
   assign bus.mem_req     = mem_req;
   assign bus.mem_addr    = mem_addr;

   // Next-state: redirect beats dequeue/enqueue; issue only when the post-edge
   // count leaves room, which keeps count <= DEPTH with one request in flight.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      count_nxt    = count;
      rd_ptr_nxt   = rd_ptr;
      wr_ptr_nxt   = wr_ptr;
      mem_addr_nxt = mem_addr;
      mem_req_nxt  = mem_req;

      deq = (count != '0) && bus.instr_ready && !bus.redirect;
      enq = (state == S_REQ) && bus.mem_ack && !bus.redirect;

      if (bus.redirect) begin
         count_nxt    = '0;
         rd_ptr_nxt   = '0;
         wr_ptr_nxt   = '0;
         fetch_pc_nxt = bus.redirect_pc;
      end else begin
         if (enq) begin
            wr_ptr_nxt   = wr_ptr + PTR_W'(1);
            fetch_pc_nxt = fetch_pc + 16'd1;
         end
         if (deq) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
         end
         if (enq && !deq) begin
            count_nxt = count + CNT_W'(1);
         end else if (deq && !enq) begin
            count_nxt = count - CNT_W'(1);
         end
      end

      space = (count_nxt < DEPTH_C);

      case (state)
         S_IDLE: begin
            if (space) begin
               state_nxt    = S_REQ;
               mem_addr_nxt = fetch_pc_nxt;
            end
         end
         S_REQ: begin
            if (bus.mem_ack) begin
               if (space) begin
                  state_nxt    = S_REQ;
                  mem_addr_nxt = fetch_pc_nxt;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else if (bus.redirect) begin
               // old request still in flight: keep its address until acked
               state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            // stale ack is swallowed; resume at the (possibly updated) fetch_pc
            if (bus.mem_ack) begin
               state_nxt    = S_REQ;
               mem_addr_nxt = fetch_pc_nxt;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      mem_req_nxt = (state_nxt != S_IDLE);
   end

   // State, control and FIFO storage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= 16'h0000;
            data_mem[i] <= 16'h0000;
         end
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         count    <= count_nxt;
         rd_ptr   <= rd_ptr_nxt;
         wr_ptr   <= wr_ptr_nxt;
         mem_req  <= mem_req_nxt;
         mem_addr <= mem_addr_nxt;
         if (enq) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= bus.mem_rdata;
         end
      end
   end

endmodule
